ahb_apb_bridge: RTL and testbench
=================================

# ahb_apb_bridge

AHB-Lite responder that converts each accepted AHB transfer into a single APB access, so low-speed peripherals can sit behind one decoder slot (`HSELx` bit) on the AHB fabric. It occupies a slave position alongside the existing slaves: it drives `HRDATA`, `HREADYOUT` and `HRESP` into the multiplexor, and it acts as the APB initiator toward one APB peripheral. Bursts are broken into independent single APB accesses. Each access is a two-phase APB transfer (SETUP, then ACCESS).

## Interface
- `WIDTH`, 32, AHB/APB data and HADDR width
- `PADDR_W`, 16, APB address width; `PADDR = HADDR[PADDR_W-1:0]`

- `HCLK` in 1: single clock for the AHB and APB sides
- `HRESET` in 1: reset, asynchronous, active-high
- `HSELx` in 1: decoder select for this block
- `HADDR` in WIDTH: AHB address
- `HWRITE` in 1: transfer direction
- `HSIZE` in 3: transfer size
- `HTRANS` in trans_t: transfer type
- `HREADY` in 1: muxed bus ready
- `HWDATA` in WIDTH: write data
- `HRDATA` out WIDTH: read data
- `HREADYOUT` out 1: this block's ready
- `HRESP` out 1: 1 = ERROR
- `PSEL` out 1: APB select
- `PENABLE` out 1: APB enable
- `PWRITE` out 1: APB direction
- `PADDR` out PADDR_W: APB address
- `PWDATA` out WIDTH: APB write data
- `PRDATA` in WIDTH: APB read data
- `PREADY` in 1: APB ready
- `PSLVERR` in 1: APB error
- `PSTRB` out 4: byte strobes; present only with `APB_PSTRB_EN`

## Operation
- Valid transfer: `HSELx & HREADY & HTRANS∈{NONSEQ,SEQ}` at a rising edge. A valid transfer is accepted only in IDLE or ERR2.
- On acceptance: latch HADDR, HWRITE and HSIZE, then go to SETUP.
- IDLE/BUSY transfers, or no select: OKAY response, zero wait, no APB activity.
- FSM `apb_state_t`:
  - IDLE: `HREADYOUT=1`, `HRESP=0`, `PSEL=0`.
  - SETUP: `PSEL=1`, `PENABLE=0`, `HREADYOUT=0`. Always goes to ACCESS on the next edge.
  - ACCESS: `PSEL=1`, `PENABLE=1`, `HREADYOUT=0`.
    - `!PREADY`: stay in ACCESS.
    - `PREADY & !PSLVERR`: go to IDLE. On a read, capture PRDATA into HRDATA.
    - `PREADY & PSLVERR`: go to ERR1.
  - ERR1: `HRESP=1`, `HREADYOUT=0`, `PSEL=0`. Goes to ERR2.
  - ERR2: `HRESP=1`, `HREADYOUT=1`. A valid transfer here goes to SETUP; otherwise go to IDLE.
- PADDR, PWRITE and PSTRB hold their latched values from SETUP through ACCESS.
- `PWDATA = HWDATA` combinationally. The AHB initiator holds HWDATA stable for the whole stalled data phase.
- HRDATA changes only when a read completes successfully. It holds its value across writes and errors.
- Reset values: state IDLE, `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`, `PSEL=0`, `PENABLE=0`, `PWRITE=0`, `PADDR=0`, `PSTRB=0`.
- Reset asserted mid-transfer: all outputs return to their reset values immediately (asynchronously). The APB access is abandoned.

## Timing
- Address-phase edge → SETUP. HREADYOUT is low for `2 + N` cycles, where N is the number of ACCESS cycles with `PREADY=0`.
- HRDATA is valid in the cycle in which HREADYOUT returns high.
- Back-to-back transfers: a transfer accepted on the completion edge starts SETUP on the next cycle, with no idle gap.
- Error response: exactly two cycles with `HRESP=1`; HREADYOUT is 0 in the first and 1 in the second.

## Configuration
- `APB_PSTRB_EN` defined:
  - PSTRB port exists.
  - Writes:
    - byte: `1<<HADDR[1:0]`
    - halfword: `4'b0011<<{HADDR[1],1'b0}`
    - word: `4'b1111`
  - Reads drive `PSTRB=0`.
  - `HSIZE>2` goes straight to ERR1 without asserting PSEL.
- `APB_PSTRB_EN` undefined:
  - No PSTRB port.
  - No size checking; every size is forwarded as a full-word APB access.

## Structure
- Package `util` gains:
  - `apb_state_t` enum {IDLE, SETUP, ACCESS, ERR1, ERR2}
  - HSIZE constants: `SIZE_BYTE=0`, `SIZE_HALF=1`, `SIZE_WORD=2`
  - existing `trans_t` (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3) is reused
- Sub-module `apb_strb_gen`: combinational HSIZE/HADDR → PSTRB and size-error flag. Instantiated only under `APB_PSTRB_EN`.

## Test plan
- **Reset:** assert HRESET → `HREADYOUT=1`, `HRESP=0`, `PSEL=0`, `PENABLE=0`, `HRDATA=0`. Release → no APB activity while `HTRANS=IDLE`.
- **Single write:** HADDR=0x00000104, HWDATA=0xDEADBEEF, `PREADY=1`:
  - cycle 1: `PSEL=1`, `PENABLE=0`
  - cycle 2: `PENABLE=1`, `PADDR=0x0104`, `PWRITE=1`, `PWDATA=0xDEADBEEF`
  - HREADYOUT is low for exactly 2 cycles
- **Read with wait states:** PREADY low for 3 ACCESS cycles, PRDATA=0x12345678 → HREADYOUT low for 5 cycles, then `HRDATA=0x12345678` as HREADYOUT rises.
- **APB error:** `PSLVERR=1` with `PREADY=1` → HRESP high for 2 cycles; HREADYOUT 0 then 1; HRDATA unchanged.
- **Back-to-back and non-transfers:**
  - NONSEQ read issued on the completion edge → SETUP on the next cycle with no gap.
  - `HTRANS=BUSY` or `HSELx=0` → PSEL stays 0 and HREADYOUT stays 1.
  - HRESET pulse in ACCESS → PSEL/PENABLE drop immediately.
- **`APB_PSTRB_EN` (macro build only):**
  - byte write to HADDR=0x...3 → `PSTRB=4'b1000`
  - `HSIZE=3` → ERR1/ERR2 response with PSEL never asserted

Source files
------------

// File: rtl/util.sv
// Shared AHB/APB types and constants for the AHB-to-APB bridge.
package util;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'd0,
        TRANS_BUSY   = 2'd1,
        TRANS_NONSEQ = 2'd2,
        TRANS_SEQ    = 2'd3
    } trans_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } apb_state_t;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    // Only NONSEQ and SEQ carry data; IDLE and BUSY get a zero-wait OKAY.
    function automatic logic is_active_trans(input trans_t t);
        return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
    endfunction

endpackage

// File: rtl/apb_strb_gen.sv
// Combinational HSIZE/HADDR decode into APB byte strobes plus an
// unsupported-size flag. Reads always produce an all-zero strobe.
module apb_strb_gen
    import util::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] haddr_lo,
    input  logic       hwrite,
    output logic [3:0] strb,
    output logic       size_err
);

    always_comb begin
        strb     = 4'b0000;
        size_err = 1'b0;
        case (hsize)
            SIZE_BYTE: strb = 4'b0001 << haddr_lo;
            SIZE_HALF: strb = 4'b0011 << {haddr_lo[1], 1'b0};
            SIZE_WORD: strb = 4'b1111;
            default:   size_err = 1'b1;
        endcase
        if (!hwrite) begin
            strb = 4'b0000;
        end
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite responder turning each accepted transfer into one APB SETUP/ACCESS
// pair. Defining APB_PSTRB_EN adds the PSTRB port and rejects HSIZE > word.
module ahb_apb_bridge
    import util::*;
#(
    parameter int WIDTH   = 32,
    parameter int PADDR_W = 16
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSELx,
    input  logic [WIDTH-1:0]   HADDR,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  trans_t             HTRANS,
    input  logic               HREADY,
    input  logic [WIDTH-1:0]   HWDATA,
    output logic [WIDTH-1:0]   HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [PADDR_W-1:0] PADDR,
    output logic [WIDTH-1:0]   PWDATA,
    input  logic [WIDTH-1:0]   PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
`ifdef APB_PSTRB_EN
    ,
    output logic [3:0]         PSTRB
`endif
);

    apb_state_t         state;
    apb_state_t         state_nxt;
    logic               xfer_valid;
    logic               accept;
    logic               rd_done;
    logic               size_err;
    logic [PADDR_W-1:0] paddr_q;
    logic               pwrite_q;
    logic [WIDTH-1:0]   hrdata_q;

    // Upper address bits and (in the default build) HSIZE do not reach APB.
    logic unused_bits;
    assign unused_bits = ^{HADDR[WIDTH-1:PADDR_W], HSIZE};

    assign xfer_valid = HSELx && HREADY && is_active_trans(HTRANS);

`ifdef APB_PSTRB_EN
    logic [3:0] strb_nxt;
    logic [3:0] strb_q;

    apb_strb_gen u_strb_gen (
        .hsize    (HSIZE),
        .haddr_lo (HADDR[1:0]),
        .hwrite   (HWRITE),
        .strb     (strb_nxt),
        .size_err (size_err)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            strb_q <= 4'b0000;
        end else if (accept) begin
            strb_q <= strb_nxt;
        end
    end

    assign PSTRB = strb_q;
`else
    assign size_err = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                paddr_q  <= HADDR[PADDR_W-1:0];
                pwrite_q <= HWRITE;
            end
            if (rd_done) begin
                hrdata_q <= PRDATA;
            end
        end
    end

    // Only IDLE and ERR2 present HREADYOUT=1, so only they can take a new
    // address phase; an oversized transfer skips APB and goes to ERR1.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rd_done   = 1'b0;
        HREADYOUT = 1'b0;
        HRESP     = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (state)
            ST_IDLE: begin
                HREADYOUT = 1'b1;
                if (xfer_valid) begin
                    accept    = 1'b1;
                    state_nxt = size_err ? ST_ERR1 : ST_SETUP;
                end
            end
            ST_SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_nxt = ST_ERR1;
                    end else begin
                        state_nxt = ST_IDLE;
                        rd_done   = !pwrite_q;
                    end
                end
            end
            ST_ERR1: begin
                HRESP     = 1'b1;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP     = 1'b1;
                HREADYOUT = 1'b1;
                if (xfer_valid) begin
                    accept    = 1'b1;
                    state_nxt = size_err ? ST_ERR1 : ST_SETUP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign HRDATA  = hrdata_q;
    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = HWDATA;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge; HREADY is looped back from HREADYOUT
// as if the bridge were the only responder on the bus.
module tb_ahb_apb_bridge;
    import util::*;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hselx = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = SIZE_WORD;
    trans_t      htrans = TRANS_IDLE;
    logic        hready;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b1;
    logic        pslverr = 1'b0;
`ifdef APB_PSTRB_EN
    logic [3:0]  pstrb;
`endif

    assign hready = hreadyout;

    ahb_apb_bridge #(.WIDTH(32), .PADDR_W(16)) dut (
        .HCLK      (hclk),
        .HRESET    (hreset),
        .HSELx     (hselx),
        .HADDR     (haddr),
        .HWRITE    (hwrite),
        .HSIZE     (hsize),
        .HTRANS    (htrans),
        .HREADY    (hready),
        .HWDATA    (hwdata),
        .HRDATA    (hrdata),
        .HREADYOUT (hreadyout),
        .HRESP     (hresp),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr)
`ifdef APB_PSTRB_EN
        ,
        .PSTRB     (pstrb)
`endif
    );

    // ---------------- clock ----------------
    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic vec_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Per-transfer observations captured by ahb_xfer.
    int          low_cycles;
    int          hresp_hi;
    int          end_cyc;
    int          c1_cyc;
    logic        psel_seen;
    logic        c1_psel, c1_penable, c2_penable, c2_pwrite;
    logic [15:0] c2_paddr;
    logic [31:0] c2_pwdata;
    logic [3:0]  c2_pstrb;
    logic [31:0] end_hrdata;

    // ---------------- driver ----------------
    // Called at a negedge: drives one NONSEQ address phase, then the data
    // phase, and watches every negedge until HREADYOUT comes back high.
    task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] size, input int waits, input logic err,
                            input logic [31:0] rdata);
        int   wait_left;
        logic done;
        hselx  = 1'b1;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = TRANS_NONSEQ;
        @(posedge hclk);
        #1;
        hselx   = 1'b0;
        htrans  = TRANS_IDLE;
        hwdata  = wdata;
        prdata  = rdata;
        pslverr = err;
        wait_left  = waits;
        low_cycles = 0;
        hresp_hi   = 0;
        psel_seen  = 1'b0;
        done       = 1'b0;
        c1_psel = 1'b0; c1_penable = 1'b0; c2_penable = 1'b0; c2_pwrite = 1'b0;
        c2_paddr = '0; c2_pwdata = '0; c2_pstrb = '0; c1_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge hclk);
            if (hresp) hresp_hi++;
            if (psel) psel_seen = 1'b1;
            if (hreadyout) begin
                done = 1'b1;
                break;
            end
            low_cycles++;
            if (low_cycles == 1) begin
                c1_psel    = psel;
                c1_penable = penable;
                c1_cyc     = cyc;
            end
            if (low_cycles == 2) begin
                c2_penable = penable;
                c2_paddr   = paddr;
                c2_pwrite  = pwrite;
                c2_pwdata  = pwdata;
`ifdef APB_PSTRB_EN
                c2_pstrb   = pstrb;
`endif
            end
            if (penable && wait_left > 0) begin
                pready = 1'b0;
                wait_left--;
            end else begin
                pready = 1'b1;
            end
        end
        vec_check("xfer_completes", {31'd0, done}, 32'd1);
        end_hrdata = hrdata;
        end_cyc    = cyc;
        pready     = 1'b1;
        pslverr    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int prev_end;

        // Reset
        repeat (2) @(negedge hclk);
        vec_check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        vec_check("rst_hresp",     {31'd0, hresp},     32'd0);
        vec_check("rst_psel",      {31'd0, psel},      32'd0);
        vec_check("rst_penable",   {31'd0, penable},   32'd0);
        vec_check("rst_hrdata",    hrdata,             32'h0);
        vec_check("rst_pwrite",    {31'd0, pwrite},    32'd0);
        vec_check("rst_paddr",     {16'd0, paddr},     32'h0);
`ifdef APB_PSTRB_EN
        vec_check("rst_pstrb",     {28'd0, pstrb},     32'h0);
`endif
        hreset = 1'b0;
        hselx  = 1'b1;
        htrans = TRANS_IDLE;
        repeat (3) begin
            @(negedge hclk);
            vec_check("idle_psel", {31'd0, psel}, 32'd0);
        end
        hselx = 1'b0;

        // Single write, zero wait
        ahb_xfer(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, SIZE_WORD, 0, 1'b0, 32'h0);
        vec_check("wr_c1_psel",    {31'd0, c1_psel},    32'd1);
        vec_check("wr_c1_penable", {31'd0, c1_penable}, 32'd0);
        vec_check("wr_c2_penable", {31'd0, c2_penable}, 32'd1);
        vec_check("wr_c2_paddr",   {16'd0, c2_paddr},   32'h0104);
        vec_check("wr_c2_pwrite",  {31'd0, c2_pwrite},  32'd1);
        vec_check("wr_c2_pwdata",  c2_pwdata,           32'hDEAD_BEEF);
        vec_check("wr_low_cycles", low_cycles,          32'd2);
        vec_check("wr_hresp",      hresp_hi,            32'd0);
`ifdef APB_PSTRB_EN
        vec_check("wr_word_pstrb", {28'd0, c2_pstrb},   32'hF);
`endif

        // Read with three wait states
        ahb_xfer(1'b0, 32'h0000_0040, 32'h0, SIZE_WORD, 3, 1'b0, 32'h1234_5678);
        vec_check("rd_low_cycles", low_cycles,        32'd5);
        vec_check("rd_hrdata",     end_hrdata,        32'h1234_5678);
        vec_check("rd_c2_pwrite",  {31'd0, c2_pwrite}, 32'd0);
        vec_check("rd_c2_paddr",   {16'd0, c2_paddr}, 32'h0040);
`ifdef APB_PSTRB_EN
        vec_check("rd_pstrb",      {28'd0, c2_pstrb}, 32'h0);
`endif

        // APB error on a read: HRDATA must keep the previous read value
        ahb_xfer(1'b0, 32'h0000_0080, 32'h0, SIZE_WORD, 0, 1'b1, 32'hAAAA_5555);
        vec_check("err_low_cycles", low_cycles, 32'd3);
        vec_check("err_hresp_cnt",  hresp_hi,   32'd2);
        vec_check("err_hrdata",     end_hrdata, 32'h1234_5678);
        @(negedge hclk);
        vec_check("err_after_hresp", {31'd0, hresp}, 32'd0);

        // Back-to-back: the read is issued during the write's completion cycle
        ahb_xfer(1'b1, 32'h0000_0010, 32'h0BAD_F00D, SIZE_WORD, 0, 1'b0, 32'h0);
        prev_end = end_cyc;
        ahb_xfer(1'b0, 32'h0000_0200, 32'h0, SIZE_WORD, 0, 1'b0, 32'hCAFE_F00D);
        vec_check("b2b_c1_psel", {31'd0, c1_psel}, 32'd1);
        vec_check("b2b_gap",     c1_cyc - prev_end, 32'd1);
        vec_check("b2b_paddr",   {16'd0, c2_paddr}, 32'h0200);
        vec_check("b2b_hrdata",  end_hrdata, 32'hCAFE_F00D);

        // Non-transfers: BUSY while selected, NONSEQ while not selected
        hselx  = 1'b1;
        haddr  = 32'h0000_0300;
        hwrite = 1'b1;
        htrans = TRANS_BUSY;
        repeat (3) begin
            @(negedge hclk);
            vec_check("busy_psel",      {31'd0, psel},      32'd0);
            vec_check("busy_hreadyout", {31'd0, hreadyout}, 32'd1);
        end
        hselx  = 1'b0;
        htrans = TRANS_NONSEQ;
        repeat (3) begin
            @(negedge hclk);
            vec_check("nosel_psel",      {31'd0, psel},      32'd0);
            vec_check("nosel_hreadyout", {31'd0, hreadyout}, 32'd1);
        end
        htrans = TRANS_IDLE;

        // Reset pulse while in ACCESS
        hselx  = 1'b1;
        haddr  = 32'h0000_0044;
        hwrite = 1'b0;
        htrans = TRANS_NONSEQ;
        @(posedge hclk);
        #1;
        hselx  = 1'b0;
        htrans = TRANS_IDLE;
        @(negedge hclk);
        vec_check("rstmid_setup_psel", {31'd0, psel}, 32'd1);
        pready = 1'b0;
        @(negedge hclk);
        vec_check("rstmid_access_penable", {31'd0, penable}, 32'd1);
        #1;
        hreset = 1'b1;
        #1;
        vec_check("rstmid_psel",      {31'd0, psel},      32'd0);
        vec_check("rstmid_penable",   {31'd0, penable},   32'd0);
        vec_check("rstmid_hreadyout", {31'd0, hreadyout}, 32'd1);
        vec_check("rstmid_hrdata",    hrdata,             32'h0);
        #1;
        hreset = 1'b0;
        pready = 1'b1;
        @(negedge hclk);
        vec_check("rstmid_idle_psel", {31'd0, psel}, 32'd0);

        // Recovery write after the reset pulse
        ahb_xfer(1'b1, 32'h0001_0008, 32'h5A5A_A5A5, SIZE_WORD, 1, 1'b0, 32'h0);
        vec_check("rec_low_cycles", low_cycles, 32'd3);
        vec_check("rec_paddr",      {16'd0, c2_paddr}, 32'h0008);
        vec_check("rec_pwdata",     c2_pwdata, 32'h5A5A_A5A5);

`ifdef APB_PSTRB_EN
        ahb_xfer(1'b1, 32'h0000_0013, 32'h0000_00AB, SIZE_BYTE, 0, 1'b0, 32'h0);
        vec_check("strb_byte3", {28'd0, c2_pstrb}, 32'h8);
        ahb_xfer(1'b1, 32'h0000_0011, 32'h0000_00CD, SIZE_BYTE, 0, 1'b0, 32'h0);
        vec_check("strb_byte1", {28'd0, c2_pstrb}, 32'h2);
        ahb_xfer(1'b1, 32'h0000_0022, 32'h1234_0000, SIZE_HALF, 0, 1'b0, 32'h0);
        vec_check("strb_half_hi", {28'd0, c2_pstrb}, 32'hC);
        ahb_xfer(1'b1, 32'h0000_0020, 32'h0000_5678, SIZE_HALF, 0, 1'b0, 32'h0);
        vec_check("strb_half_lo", {28'd0, c2_pstrb}, 32'h3);
        ahb_xfer(1'b1, 32'h0000_0030, 32'h0, 3'd3, 0, 1'b0, 32'h0);
        vec_check("size_err_psel",  {31'd0, psel_seen}, 32'd0);
        vec_check("size_err_low",   low_cycles, 32'd1);
        vec_check("size_err_hresp", hresp_hi,   32'd2);
`endif

        repeat (2) @(negedge hclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Overall time bound in case any wait above never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
